// File: rtl/event_reduce_pkg.sv
// event_reduce_pkg: shared constants and helpers for event_reduce_filter.
//   MODE_*  : reduction selectors for the MODE parameter
//   CNT_W   : width of the rising-edge event counter
//   FILT_W  : width of the deglitch run-length counter
//   popcount: number of set bits in a 32-bit vector (enough for N_CH <= 32)
package event_reduce_pkg;

  localparam int unsigned MODE_OR  = 0;
  localparam int unsigned MODE_AND = 1;
  localparam int unsigned MODE_XOR = 2;
  localparam int unsigned MODE_MAJ = 3;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned FILT_W = 8;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/deglitch_ctr.sv
// deglitch_ctr: run-length filter. q_o follows d_i only after d_i has
// disagreed with q_o on FILT_LEN consecutive enabled edges.
//   clk_i  : clock, all state on posedge
//   rst_i  : asynchronous active-high reset (q_o and run counter to 0)
//   en_i   : 1 = filter advances, 0 = holds
//   clr_i  : synchronous clear of q_o and run counter, independent of en_i
//   d_i    : value to be filtered
//   sticky : 1 = once q_o is 1 it stays 1 until clr_i or reset
//   q_o    : filtered output
module deglitch_ctr
  import event_reduce_pkg::*;
#(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  input  logic d_i,
  input  logic sticky,
  output logic q_o
);

  localparam logic [FILT_W-1:0] LEN = FILT_W'(FILT_LEN);

  logic [FILT_W-1:0] r_cnt;
  logic [FILT_W-1:0] w_cnt_inc;
  logic [FILT_W-1:0] w_cnt_nxt;
  logic              r_q;
  logic              w_q_nxt;

  always_comb begin
    w_cnt_inc = r_cnt + FILT_W'(1);
    w_cnt_nxt = r_cnt;
    w_q_nxt   = r_q;
    if (clr_i) begin
      // Clear beats a simultaneous set: the run has to start over.
      w_cnt_nxt = '0;
      w_q_nxt   = 1'b0;
    end else if (en_i) begin
      if ((sticky && r_q) || (d_i == r_q)) begin
        w_cnt_nxt = '0;
      end else if (w_cnt_inc == LEN) begin
        w_q_nxt   = d_i;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_q   <= w_q_nxt;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/event_reduce_filter.sv
// event_reduce_filter: masks and reduces N_CH event channels (OR / AND /
// XOR / strict majority), deglitches the result, and counts rising edges.
//   clk_i     : clock, all state on posedge
//   rst_i     : asynchronous active-high reset
//   en_i      : 1 = pipeline and filter advance, 0 = hold
//   mask_i    : per-channel enable, 1 = channel participates
//   ch_i      : raw channel inputs
//   clr_i     : synchronous clear of yo, filter run, rise_o and evt_cnt_o
//   yo        : filtered, registered reduction result
//   rise_o    : high for the cycle in which yo has just gone 0->1
//   evt_cnt_o : saturating count of yo rising edges
module event_reduce_filter
  import event_reduce_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned MODE     = 0,
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned STICKY   = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [N_CH-1:0]  mask_i,
  input  logic [N_CH-1:0]  ch_i,
  input  logic             clr_i,
  output logic             yo,
  output logic             rise_o,
  output logic [CNT_W-1:0] evt_cnt_o
);

  logic [N_CH-1:0]  r_ch;
  logic [N_CH-1:0]  r_mask;
  logic             r_red;
  logic [N_CH-1:0]  w_act;
  logic [N_CH-1:0]  w_and_src;
  logic [5:0]       w_pop;
  logic [5:0]       w_k;
  logic             w_red;
  logic             w_sticky;
  logic             w_yo;
  logic             r_yo_prev;
  logic             w_rise;
  logic [CNT_W-1:0] r_evt;
  logic [CNT_W-1:0] w_evt;

  // Stage 1 (raw inputs) and stage 2 (reduction) registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ch   <= '0;
      r_mask <= '0;
      r_red  <= 1'b0;
    end else if (en_i) begin
      r_ch   <= ch_i;
      r_mask <= mask_i;
      r_red  <= w_red;
    end
  end

  // Masked channels read as 1 for AND and 0 otherwise; an all-masked
  // vector always reduces to 0.
  always_comb begin
    w_act     = r_ch & r_mask;
    w_and_src = r_ch | ~r_mask;
    w_pop     = popcount(32'(w_act));
    w_k       = popcount(32'(r_mask));
    w_red     = 1'b0;
    if (|r_mask) begin
      case (MODE)
        MODE_OR:  w_red = |w_act;
        MODE_AND: w_red = &w_and_src;
        MODE_XOR: w_red = ^w_act;
        MODE_MAJ: w_red = ({w_pop, 1'b0} > {1'b0, w_k});
        default:  w_red = 1'b0;
      endcase
    end
  end

  assign w_sticky = (STICKY != 0);

  deglitch_ctr #(
    .FILT_LEN(FILT_LEN)
  ) u_deglitch (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (en_i),
    .clr_i (clr_i),
    .d_i   (r_red),
    .sticky(w_sticky),
    .q_o   (w_yo)
  );

  // yo lives inside deglitch_ctr, so the edge is detected against a shadow
  // copy of yo. r_evt holds the count of edges already absorbed; the output
  // adds the edge currently showing so the count moves with yo, and the
  // shadow catches up on the next clock so rise_o lasts one cycle.
  assign w_rise = w_yo & ~r_yo_prev;
  assign w_evt  = (w_rise && (r_evt != '1)) ? r_evt + CNT_W'(1) : r_evt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_yo_prev <= 1'b0;
      r_evt     <= '0;
    end else if (clr_i) begin
      r_yo_prev <= 1'b0;
      r_evt     <= '0;
    end else begin
      r_yo_prev <= w_yo;
      r_evt     <= w_evt;
    end
  end

  assign yo        = w_yo;
  assign rise_o    = w_rise;
  assign evt_cnt_o = w_evt;

endmodule

// File: tb/tb_event_reduce_filter.sv
module tb_event_reduce_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [3:0] ch;
  logic [3:0] mask;

  // 0:OR F1  1:AND F1  2:XOR F1  3:MAJ F1  4:OR F3  5:OR F2 sticky  6:OR F1 N_CH=2
  logic [6:0] yo_v;
  logic [6:0] rise_v;
  logic [7:0] evt_v [7];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] ch;
    logic [3:0] exp;   // {maj, xor, and, or}
  } vec_t;

  vec_t       vecs [15];
  logic [3:0] sbq [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    event_reduce_filter #(
      .N_CH    (4),
      .MODE    (g < 4 ? g : 0),
      .FILT_LEN(g == 4 ? 3 : (g == 5 ? 2 : 1)),
      .STICKY  (g == 5 ? 1 : 0)
    ) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .en_i     (en),
      .mask_i   (mask),
      .ch_i     (ch),
      .clr_i    (clr),
      .yo       (yo_v[g]),
      .rise_o   (rise_v[g]),
      .evt_cnt_o(evt_v[g])
    );
  end

  event_reduce_filter #(
    .N_CH    (2),
    .MODE    (0),
    .FILT_LEN(1),
    .STICKY  (0)
  ) u_n2 (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .mask_i   (mask[1:0]),
    .ch_i     (ch[1:0]),
    .clr_i    (clr),
    .yo       (yo_v[6]),
    .rise_o   (rise_v[6]),
    .evt_cnt_o(evt_v[6])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%h required 0x%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pk(input int k);
    return {6'd0, yo_v[k], rise_v[k], evt_v[k]};
  endfunction

  function automatic logic [15:0] ex(input logic y, input logic r, input logic [7:0] e);
    return {6'd0, y, r, e};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       flag;
    logic       snap_yo;
    logic [7:0] snap_evt;
    logic [3:0] e;

    vecs[0]  = '{4'b1111, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b1111, 4'b0001, 4'b0101};
    vecs[2]  = '{4'b1111, 4'b0011, 4'b0001};
    vecs[3]  = '{4'b1111, 4'b0111, 4'b1101};
    vecs[4]  = '{4'b1111, 4'b1111, 4'b1011};
    vecs[5]  = '{4'b0011, 4'b1100, 4'b0000};
    vecs[6]  = '{4'b0011, 4'b0011, 4'b1011};
    vecs[7]  = '{4'b0101, 4'b1010, 4'b0000};
    vecs[8]  = '{4'b0000, 4'b1111, 4'b0000};
    vecs[9]  = '{4'b0111, 4'b0011, 4'b1001};
    vecs[10] = '{4'b0001, 4'b0001, 4'b1111};
    vecs[11] = '{4'b1110, 4'b0001, 4'b0000};
    vecs[12] = '{4'b1000, 4'b1000, 4'b1111};
    vecs[13] = '{4'b0000, 4'b0000, 4'b0000};
    vecs[14] = '{4'b1111, 4'b1011, 4'b1101};

    rst  = 1'b1;
    en   = 1'b1;
    clr  = 1'b0;
    ch   = 4'b0000;
    mask = 4'b1111;
    tick();
    tick();
    for (int k = 0; k < 7; k++) chk($sformatf("reset_dut%0d", k), pk(k), 16'd0);
    rst = 1'b0;

    // Reduction table through the four FILT_LEN=1 instances (3-edge latency).
    for (int i = 0; i < 17; i++) begin
      if (i < 15) begin
        mask = vecs[i].mask;
        ch   = vecs[i].ch;
        sbq.push_back(vecs[i].exp);
      end
      tick();
      if (i >= 2) begin
        e = sbq.pop_front();
        chk($sformatf("table_vec%0d", i - 2), {12'd0, yo_v[3], yo_v[2], yo_v[1], yo_v[0]}, {12'd0, e});
      end
    end

    ch   = 4'b0000;
    mask = 4'b1111;
    repeat (8) tick();

    // Two-channel OR, FILT_LEN=1.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("n2_clr", pk(6), ex(1'b0, 1'b0, 8'd0));
    ch = 4'b0001;
    tick();
    tick();
    chk("n2_edge2", pk(6), ex(1'b0, 1'b0, 8'd0));
    tick();
    chk("n2_edge3_rise", pk(6), ex(1'b1, 1'b1, 8'd1));
    tick();
    chk("n2_edge4", pk(6), ex(1'b1, 1'b0, 8'd1));
    ch = 4'b0000;
    tick();
    tick();
    chk("n2_fall_edge2", pk(6), ex(1'b1, 1'b0, 8'd1));
    tick();
    chk("n2_fall_edge3", pk(6), ex(1'b0, 1'b0, 8'd1));

    // FILT_LEN=3: short pulse rejected, 3-cycle pulse passes 5 edges after onset.
    repeat (8) tick();
    ch = 4'b0001;
    tick();
    tick();
    ch   = 4'b0000;
    flag = 1'b0;
    repeat (8) begin
      tick();
      if (yo_v[4] !== 1'b0) flag = 1'b1;
    end
    chk("f3_short_pulse", {15'd0, flag}, 16'd0);
    ch = 4'b0001;
    tick();
    tick();
    tick();
    ch = 4'b0000;
    tick();
    chk("f3_edge4", {14'd0, yo_v[4], rise_v[4]}, 16'b00);
    tick();
    chk("f3_edge5", {14'd0, yo_v[4], rise_v[4]}, 16'b11);
    tick();
    chk("f3_edge6", {14'd0, yo_v[4], rise_v[4]}, 16'b10);
    tick();
    chk("f3_edge7", {15'd0, yo_v[4]}, 16'd1);
    tick();
    chk("f3_edge8", {15'd0, yo_v[4]}, 16'd0);

    // Sticky, FILT_LEN=2.
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("st_clr", pk(5), ex(1'b0, 1'b0, 8'd0));
    ch = 4'b0001;
    tick();
    tick();
    tick();
    chk("st_edge3", pk(5), ex(1'b0, 1'b0, 8'd0));
    tick();
    chk("st_edge4", pk(5), ex(1'b1, 1'b1, 8'd1));
    ch   = 4'b0000;
    flag = 1'b0;
    repeat (8) begin
      tick();
      if (yo_v[5] !== 1'b1) flag = 1'b1;
    end
    chk("st_hold", {15'd0, flag}, 16'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("st_clr2", pk(5), ex(1'b0, 1'b0, 8'd0));
    ch = 4'b0001;
    tick();
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("st_clr_wins", pk(5), ex(1'b0, 1'b0, 8'd0));
    tick();
    chk("st_after_clr1", pk(5), ex(1'b0, 1'b0, 8'd0));
    tick();
    chk("st_after_clr2", pk(5), ex(1'b1, 1'b1, 8'd1));

    // Event counting, freeze and saturation on the OR FILT_LEN=1 instance.
    ch = 4'b0000;
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("or_clr", pk(0), ex(1'b0, 1'b0, 8'd0));
    for (int i = 0; i < 20; i++) begin
      ch = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    ch = 4'b0000;
    repeat (4) tick();
    chk("or_evt10", {8'd0, evt_v[0]}, 16'd10);
    for (int i = 0; i < 40; i++) begin
      ch = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    en       = 1'b0;
    snap_yo  = yo_v[0];
    snap_evt = evt_v[0];
    flag     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ch = (i % 2 == 0) ? 4'b0000 : 4'b0001;
      tick();
      if ((yo_v[0] !== snap_yo) || (evt_v[0] !== snap_evt)) flag = 1'b1;
    end
    chk("or_freeze", {15'd0, flag}, 16'd0);
    chk("or_freeze_rise", {15'd0, rise_v[0]}, 16'd0);
    en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      ch = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    ch = 4'b0000;
    repeat (4) tick();
    chk("or_evt_sat", {8'd0, evt_v[0]}, 16'd255);
    for (int i = 0; i < 20; i++) begin
      ch = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    ch = 4'b0000;
    repeat (4) tick();
    chk("or_evt_sat_hold", {8'd0, evt_v[0]}, 16'd255);

    // Asynchronous reset in the middle of a FILT_LEN=3 run.
    ch = 4'b0001;
    repeat (4) tick();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_or", pk(0), 16'd0);
    chk("rst_async_f3", pk(4), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("post_rst_or_edge3", pk(0), ex(1'b1, 1'b1, 8'd1));
    chk("post_rst_f3_edge3", {15'd0, yo_v[4]}, 16'd0);
    tick();
    chk("post_rst_f3_edge4", {15'd0, yo_v[4]}, 16'd0);
    tick();
    chk("post_rst_f3_edge5", {15'd0, yo_v[4]}, 16'd1);

    chk("sb_empty", 16'(sbq.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/event_reduce_filter.md
EVENT_REDUCE_FILTER -- requirements
Module: event_reduce_filter

Interface
REQ-001 Parameter N_CH, default 4, number of input channels (legal 2..32).
REQ-002 Parameter MODE, default 0, reduction: 0=OR, 1=AND, 2=XOR, 3=majority (strictly more than half of enabled channels).
REQ-003 Parameter FILT_LEN, default 3, consecutive cycles of disagreement before yo changes (legal 1..255).
REQ-004 Parameter STICKY, default 0; 1 = yo latches high until clr_i.
REQ-005 clk_i  input  1  clock; all state on posedge.
REQ-006 rst_i  input  1  reset, asynchronous, active-high.
REQ-007 en_i  input  1  1 = pipeline and filter advance; 0 = all state holds.
REQ-008 mask_i  input  N_CH  per-channel enable; 1 = channel participates.
REQ-009 ch_i  input  N_CH  raw channel inputs, synchronous to clk_i.
REQ-010 clr_i  input  1  synchronous clear of sticky state, filter and counter.
REQ-011 yo  output  1  filtered, registered reduction result.
REQ-012 rise_o  output  1  one-cycle pulse, high in the cycle yo goes 0->1.
REQ-013 evt_cnt_o  output  8  saturating count of yo rising edges.

Function
REQ-014 Stage 1 SHALL register ch_i and mask_i on every enabled edge.
REQ-015 Stage 2 SHALL register the reduction of stage-1 values per MODE; masked channels are ignored (AND treats them as 1, OR/XOR/majority as 0).
REQ-016 If all channels are masked, the stage-2 result SHALL be 0 in every MODE.
REQ-017 Majority with k enabled channels SHALL be 1 only when the count of enabled ones exceeds k/2; a tie yields 0.
REQ-018 The filter counter SHALL reset to 0 on any enabled edge where the stage-2 result r equals yo.
REQ-019 On an enabled edge with r != yo, the counter SHALL increment; on the edge where it would reach FILT_LEN, yo <= r and the counter <= 0.
REQ-020 Latency SHALL be 2+FILT_LEN enabled edges from a stable ch_i change to yo (FILT_LEN=1: 3 edges).
REQ-021 A disagreement shorter than FILT_LEN cycles SHALL leave yo unchanged.
REQ-022 With STICKY=1, once yo=1 the filter SHALL NOT drive it to 0; only clr_i or reset does.
REQ-023 When clr_i=1 (regardless of en_i), yo, the filter counter, rise_o and evt_cnt_o SHALL become 0 on that edge; pipeline stages still advance if en_i=1.
REQ-024 clr_i SHALL win over a simultaneous filter set; yo may re-assert only after a fresh FILT_LEN run.
REQ-025 rise_o SHALL be registered, asserted for exactly the edge on which yo goes 0->1, else 0.
REQ-026 evt_cnt_o SHALL increment on each yo 0->1 transition and saturate at 255.
REQ-027 With en_i=0, all registers except clear targets SHALL hold and rise_o SHALL be 0.

Reset
REQ-028 rst_i SHALL asynchronously set stage 1, stage 2, filter counter, yo, rise_o and evt_cnt_o to 0.
REQ-029 Deassertion SHALL require no extra cycles; the first enabled edge after release samples ch_i normally.
REQ-030 Reset asserted mid-filter-run SHALL discard the partial count.

Structure
REQ-031 Package event_reduce_pkg SHALL hold MODE constants (MODE_OR, MODE_AND, MODE_XOR, MODE_MAJ), CNT_W=8 and FILT_W=8.
REQ-032 The filter counter and yo update SHALL live in one sub-module, deglitch_ctr (ports: clk_i, rst_i, en_i, clr_i, d_i, sticky, q_o).
REQ-033 Reduction logic SHALL be combinational in the top, feeding the stage-2 register.

Verification
REQ-034 N_CH=2, MODE=0, FILT_LEN=1, STICKY=0, mask=11: ch=01 held -> yo=1 on 3rd edge, rise_o pulse, evt_cnt_o=1; ch=00 -> yo=0 after 3 edges.
REQ-035 FILT_LEN=3, MODE=0: 2-cycle pulse on ch[0] -> yo stays 0; 3-cycle pulse -> yo=1 exactly 5 edges after onset.
REQ-036 MODE=3, N_CH=4, mask=1111: ch=0011 -> yo stays 0 (tie); ch=0111 -> yo=1; mask=0000 -> yo returns to 0.
REQ-037 STICKY=1: set yo=1, drop ch -> yo holds 1; clr_i together with a set edge -> yo=0, then 1 again after FILT_LEN.
REQ-038 300 rising events -> evt_cnt_o saturates at 255; en_i=0 for 10 cycles mid-run -> yo/counter frozen; rst_i mid-run -> all outputs 0 immediately.
REQ-039 Formal: with N_CH=2, MODE=0, FILT_LEN=1, STICKY=0, mask=11, en_i=1, clr_i=0, yo SHALL be equivalent to a registered ai|bi delayed by two further stages.
